// File: rtl/quad_enc_pkg.sv
// quad_enc_pkg: shared types, detent code and parameter defaults for the encoder front end
package quad_enc_pkg;
  typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3} state_t;
  localparam logic [1:0] DETENT_AB = 2'b11;
  localparam int WIDTH_DEF = 7;
  localparam int MAX_VALUE_DEF = 99;
  localparam int RESET_VALUE_DEF = 0;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
endpackage

// File: rtl/enc_debounce.sv
// enc_debounce: synchroniser plus stable-count debouncer for one encoder phase
module enc_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= {SYNC_STAGES{INIT}};
    else sync <= {sync[SYNC_STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q   <= INIT;
      cnt <= '0;
    end else if (ena) begin
      if (s == q) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        q   <= s;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/quad_enc_counter.sv
// quad_enc_counter: debounced quadrature decoder driving a saturating set-point register
module quad_enc_counter
  import quad_enc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_VALUE = MAX_VALUE_DEF,
  parameter int RESET_VALUE = RESET_VALUE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             step_up,
  output logic             step_dn,
  output logic             zero
);
  logic [1:0] ab;
  state_t state, state_n;
  logic up_c, dn_c;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] value_n;
  enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(DETENT_AB[1])) u_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .d(enc_a), .q(ab[1])
  );
  enc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INIT(DETENT_AB[0])) u_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .d(enc_b), .q(ab[0])
  );
  always_comb begin
    state_n = state;
    up_c = 1'b0;
    dn_c = 1'b0;
    case (state)
      IDLE: state_n = ab == 2'b01 ? CW1 : ab == 2'b10 ? CCW1 : IDLE;
      CW1:  state_n = ab == 2'b00 ? CW2 : ab == DETENT_AB ? IDLE : CW1;
      CW2:  state_n = ab == 2'b10 ? CW3 : ab == 2'b01 ? CW1 : CW2;
      CW3: begin
        state_n = ab == DETENT_AB ? IDLE : ab == 2'b00 ? CW2 : CW3;
        up_c = ab == DETENT_AB;
      end
      CCW1: state_n = ab == 2'b00 ? CCW2 : ab == DETENT_AB ? IDLE : CCW1;
      CCW2: state_n = ab == 2'b01 ? CCW3 : ab == 2'b10 ? CCW1 : CCW2;
      CCW3: begin
        state_n = ab == DETENT_AB ? IDLE : ab == 2'b00 ? CCW2 : CCW3;
        dn_c = ab == DETENT_AB;
      end
      default: state_n = IDLE;
    endcase
  end
  assign sum = {2'b00, value} + (WIDTH+2)'(up_c) - (WIDTH+2)'(dn_c) - (WIDTH+2)'(dec);
  always_comb
    value_n = load ? (load_value > WIDTH'(MAX_VALUE) ? WIDTH'(MAX_VALUE) : load_value)
            : sum[WIDTH+1] ? '0
            : sum > (WIDTH+2)'(MAX_VALUE) ? WIDTH'(MAX_VALUE) : sum[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      value   <= WIDTH'(RESET_VALUE);
      zero    <= RESET_VALUE == 0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else if (ena) begin
      state   <= state_n;
      value   <= value_n;
      zero    <= value_n == '0;
      step_up <= up_c;
      step_dn <= dn_c;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end
endmodule

// File: tb/tb_quad_enc_counter.sv
// tb_quad_enc_counter: directed vector and sequence checks for quad_enc_counter
module tb_quad_enc_counter;
  import quad_enc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic dec = 1'b0;
  logic load = 1'b0;
  logic [6:0] load_value = '0;
  logic [6:0] value;
  logic step_up, step_dn, zero;
  int n_chk = 0;
  int n_fail = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int moved = 0;
  int u0, d0;
  typedef struct {
    logic ld;
    logic [6:0] lv;
    logic dc;
    logic [6:0] ev;
    logic ez;
  } vec_t;
  vec_t vt[8];
  quad_enc_counter #(.WIDTH(7), .MAX_VALUE(99), .RESET_VALUE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .enc_a(enc_a), .enc_b(enc_b), .dec(dec),
    .load(load), .load_value(load_value), .value(value), .step_up(step_up),
    .step_dn(step_dn), .zero(zero)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (step_up) up_cnt++;
    if (step_dn) dn_cnt++;
    if (dut.state != IDLE) moved = 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] ab, input int n);
    {enc_a, enc_b} = ab;
    repeat (n) tick();
  endtask
  task automatic set_val(input logic [6:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask
  task automatic cw_detent();
    drive(2'b01, 8); drive(2'b00, 8); drive(2'b10, 8); drive(2'b11, 8);
  endtask
  task automatic ccw_detent();
    drive(2'b10, 8); drive(2'b00, 8); drive(2'b01, 8); drive(2'b11, 8);
  endtask
  task automatic cw_to_last();
    drive(2'b01, 8); drive(2'b00, 8); drive(2'b10, 8); drive(2'b11, 6);
  endtask
  task automatic ccw_to_last();
    drive(2'b10, 8); drive(2'b00, 8); drive(2'b01, 8); drive(2'b11, 6);
  endtask
  initial begin
    vt[0] = '{1'b1, 7'd120, 1'b0, 7'd99, 1'b0};
    vt[1] = '{1'b0, 7'd0,   1'b1, 7'd98, 1'b0};
    vt[2] = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b1};
    vt[3] = '{1'b0, 7'd0,   1'b1, 7'd0,  1'b1};
    vt[4] = '{1'b1, 7'd1,   1'b0, 7'd1,  1'b0};
    vt[5] = '{1'b0, 7'd0,   1'b1, 7'd0,  1'b1};
    vt[6] = '{1'b1, 7'd127, 1'b0, 7'd99, 1'b0};
    vt[7] = '{1'b1, 7'd0,   1'b0, 7'd0,  1'b1};
    repeat (2) tick();
    chk("reset value", value, 0);
    chk("reset zero", zero, 1);
    chk("reset step_up", step_up, 0);
    chk("reset step_dn", step_dn, 0);
    rst_n = 1'b1;
    repeat (4) tick();
    drive(2'b01, 8); drive(2'b00, 8); drive(2'b10, 8);
    u0 = up_cnt;
    drive(2'b11, 6);
    chk("latency value before", value, 0);
    tick();
    chk("latency value", value, 1);
    chk("latency step_up", step_up, 1);
    chk("latency zero", zero, 0);
    tick();
    chk("step_up one cycle", step_up, 0);
    repeat (4) tick();
    chk("one detent pulses", up_cnt - u0, 1);
    for (int i = 0; i < 8; i++) begin
      load = vt[i].ld;
      load_value = vt[i].lv;
      dec = vt[i].dc;
      tick();
      load = 1'b0;
      dec = 1'b0;
      chk($sformatf("vec%0d value", i), value, vt[i].ev);
      chk($sformatf("vec%0d zero", i), zero, vt[i].ez);
    end
    u0 = up_cnt;
    for (int i = 0; i < 100; i++) cw_detent();
    chk("cw saturate value", value, 99);
    chk("cw saturate pulses", up_cnt - u0, 100);
    set_val(0);
    d0 = dn_cnt;
    for (int i = 0; i < 3; i++) ccw_detent();
    chk("ccw floor value", value, 0);
    chk("ccw floor pulses", dn_cnt - d0, 3);
    set_val(10);
    u0 = up_cnt;
    d0 = dn_cnt;
    moved = 0;
    drive(2'b01, 3); drive(2'b11, 12);
    drive(2'b10, 3); drive(2'b11, 12);
    chk("glitch fsm moved", moved, 0);
    chk("glitch value", value, 10);
    chk("glitch pulses", (up_cnt - u0) + (dn_cnt - d0), 0);
    drive(2'b01, 8); drive(2'b00, 8); drive(2'b01, 8); drive(2'b11, 8);
    chk("reverse pulses", (up_cnt - u0) + (dn_cnt - d0), 0);
    chk("reverse value", value, 10);
    chk("reverse state", int'(dut.state), int'(IDLE));
    drive(2'b00, 8);
    chk("invalid jump state", int'(dut.state), int'(IDLE));
    drive(2'b11, 8);
    set_val(50);
    cw_to_last();
    dec = 1'b1;
    tick();
    dec = 1'b0;
    chk("up+dec value 50", value, 50);
    chk("up+dec step_up", step_up, 1);
    repeat (2) tick();
    set_val(120);
    chk("load clamp", value, 99);
    cw_to_last();
    dec = 1'b1;
    tick();
    dec = 1'b0;
    chk("up+dec value 99", value, 99);
    repeat (2) tick();
    set_val(50);
    ccw_to_last();
    load = 1'b1;
    load_value = 7'd20;
    tick();
    load = 1'b0;
    chk("load beats step_dn", value, 20);
    repeat (2) tick();
    set_val(1);
    ccw_to_last();
    dec = 1'b1;
    tick();
    dec = 1'b0;
    chk("dn+dec floor value", value, 0);
    chk("dn+dec floor zero", zero, 1);
    repeat (2) tick();
    set_val(7);
    ena = 1'b0;
    dec = 1'b1;
    tick();
    dec = 1'b0;
    ena = 1'b1;
    chk("ena low holds value", value, 7);
    set_val(5);
    drive(2'b01, 8); drive(2'b00, 8);
    rst_n = 1'b0;
    #1;
    chk("async reset value", value, 0);
    chk("async reset zero", zero, 1);
    tick();
    rst_n = 1'b1;
    u0 = up_cnt;
    d0 = dn_cnt;
    drive(2'b00, 8); drive(2'b10, 8); drive(2'b11, 8);
    chk("after reset value", value, 0);
    chk("after reset pulses", (up_cnt - u0) + (dn_cnt - d0), 0);
    chk("after reset state", int'(dut.state), int'(IDLE));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
